// File: rtl/mist_spi_pkg.sv
// Shared encodings for the MiST io-controller SPI host: select codes, FSM
// state codes and the select-vector helper.
package mist_spi_pkg;

    localparam logic [1:0] SEL_SS2  = 2'd0;
    localparam logic [1:0] SEL_SS3  = 2'd1;
    localparam logic [1:0] SEL_SS4  = 2'd2;
    localparam logic [1:0] SEL_CONF = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_GAP   = 3'd1;
    localparam state_t ST_LEAD  = 3'd2;
    localparam state_t ST_LOW   = 3'd3;
    localparam state_t ST_HIGH  = 3'd4;
    localparam state_t ST_TRAIL = 3'd5;

    // Active-low select vector, bit order {CONF_DATA0, SS4, SS3, SS2}.
    function automatic logic [3:0] sel_vec(input logic [1:0] s, input logic en);
        logic [3:0] v;
        v = 4'hF;
        if (en) v[s] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Loadable down-counter: tick is high on the last cycle of every CLK_DIV-cycle
// phase; load restarts the phase.
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (reset || load) cnt <= RELOAD;
        else if (cnt != '0) cnt <= cnt - CW'(1);
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/mist_spi_host.sv
// Byte-serial SPI mode-0 master driving the MiST core's SS2/SS3/SS4/CONF_DATA0
// selects; a select may be held across bytes and is released on demand.
module mist_spi_host
    import mist_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] sel,
    input  logic       keep,
    input  logic [7:0] tx_data,
    input  logic       release_ss,
    output logic       busy,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_ss2_n,
    output logic       spi_ss3_n,
    output logic       spi_ss4_n,
    output logic       conf_data0_n
);

    state_t     state;
    logic [1:0] sel_r;
    logic       keep_r;
    logic       held;
    logic [1:0] held_sel;
    logic       guard;
    logic [3:0] ss_n;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [2:0] bitcnt;
    logic       tick;
    logic       load;

    // Every tick outside IDLE ends a phase, so the divider restarts on it.
    assign load = (state == ST_IDLE) || tick;

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (load),
        .tick    (tick)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= ST_IDLE;
            sel_r    <= SEL_SS2;
            keep_r   <= 1'b0;
            held     <= 1'b0;
            held_sel <= SEL_SS2;
            guard    <= 1'b0;
            ss_n     <= 4'hF;
            tx_sh    <= 8'h00;
            rx_sh    <= 8'h00;
            bitcnt   <= 3'd0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_sh  <= tx_data;
                        sel_r  <= sel;
                        keep_r <= keep;
                        bitcnt <= 3'd0;
                        busy   <= 1'b1;
                        guard  <= 1'b0;
                        if (!held) begin
                            ss_n     <= sel_vec(sel, 1'b1);
                            held     <= 1'b1;
                            held_sel <= sel;
                            state    <= ST_LEAD;
                        end else if (held_sel == sel) begin
                            // Same target still selected: go straight to the first bit.
                            spi_mosi <= tx_data[7];
                            state    <= ST_LOW;
                        end else begin
                            ss_n  <= 4'hF;
                            held  <= 1'b0;
                            state <= ST_GAP;
                        end
                    end else if (release_ss) begin
                        ss_n <= 4'hF;
                        held <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (guard) begin
                            guard <= 1'b0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            ss_n     <= sel_vec(sel_r, 1'b1);
                            held     <= 1'b1;
                            held_sel <= sel_r;
                            state    <= ST_LEAD;
                        end
                    end
                end
                ST_LEAD: begin
                    if (tick) begin
                        spi_mosi <= tx_sh[7];
                        state    <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tick) begin
                        spi_sck <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], spi_miso};
                        state   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        spi_sck <= 1'b0;
                        if (bitcnt == 3'd7) begin
                            bitcnt   <= 3'd0;
                            rx_data  <= rx_sh;
                            rx_valid <= 1'b1;
                            if (keep_r) begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_TRAIL;
                            end
                        end else begin
                            bitcnt   <= bitcnt + 3'd1;
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                            spi_mosi <= tx_sh[6];
                            state    <= ST_LOW;
                        end
                    end
                end
                ST_TRAIL: begin
                    // Deselect, then a guard gap before reporting idle.
                    if (tick) begin
                        ss_n  <= 4'hF;
                        held  <= 1'b0;
                        guard <= 1'b1;
                        state <= ST_GAP;
                    end
                end
                default: begin
                    ss_n    <= 4'hF;
                    held    <= 1'b0;
                    busy    <= 1'b0;
                    spi_sck <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_ss2_n    = ss_n[SEL_SS2];
    assign spi_ss3_n    = ss_n[SEL_SS3];
    assign spi_ss4_n    = ss_n[SEL_SS4];
    assign conf_data0_n = ss_n[SEL_CONF];

endmodule

// File: tb/tb_mist_spi_host.sv
// Directed bench for mist_spi_host (CLK_DIV=4) with a mode-0 slave model that
// shifts out a preset byte and captures MOSI at every SCK rise.
module tb_mist_spi_host;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       keep = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       release_ss = 1'b0;
    logic       busy, rx_valid, spi_sck, spi_mosi, spi_miso;
    logic [7:0] rx_data;
    logic       spi_ss2_n, spi_ss3_n, spi_ss4_n, conf_data0_n;
    logic [3:0] ss_v;

    logic [7:0] slave_byte = 8'h00;
    logic       slave_ld = 1'b0;
    logic [7:0] slave_sh = 8'h00;
    logic [7:0] mosi_cap = 8'h00;
    int         mosi_n = 0;

    int n_vec = 0;
    int n_err = 0;
    int first, last, rvc, nrv, bz, hi_cnt, first_sck, allhi;
    logic [7:0] rvd;

    mist_spi_host #(.CLK_DIV(4)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .start        (start),
        .sel          (sel),
        .keep         (keep),
        .tx_data      (tx_data),
        .release_ss   (release_ss),
        .busy         (busy),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_ss2_n    (spi_ss2_n),
        .spi_ss3_n    (spi_ss3_n),
        .spi_ss4_n    (spi_ss4_n),
        .conf_data0_n (conf_data0_n)
    );

    always #5 clk_sys = ~clk_sys;

    assign ss_v     = {conf_data0_n, spi_ss4_n, spi_ss3_n, spi_ss2_n};
    assign spi_miso = slave_sh[7];

    always @(posedge spi_sck or posedge slave_ld) begin
        if (slave_ld) begin
            slave_sh <= slave_byte;
            mosi_cap <= 8'h00;
            mosi_n   <= 0;
        end else begin
            slave_sh <= {slave_sh[6:0], 1'b0};
            mosi_cap <= {mosi_cap[6:0], spi_mosi};
            mosi_n   <= mosi_n + 1;
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [1:0] s, input logic k, input logic [7:0] d, input logic [7:0] sl);
        slave_byte = sl;
        slave_ld = 1'b1;
        #1;
        slave_ld = 1'b0;
        sel = s;
        keep = k;
        tx_data = d;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Observe cycles c0..c0+n-1 with idx as the select of interest.
    task automatic watch(input int c0, input int n, input int idx);
        first = -1; last = -1; rvc = -1; rvd = 8'h00; nrv = 0;
        bz = -1; hi_cnt = 0; first_sck = -1; allhi = 0;
        for (int c = c0; c < c0 + n; c++) begin
            if (!ss_v[idx]) begin
                if (first < 0) first = c;
                last = c;
            end else hi_cnt++;
            if (first < 0 && ss_v == 4'hF) allhi++;
            if (spi_sck && first_sck < 0) first_sck = c;
            if (rx_valid) begin
                nrv++;
                rvc = c;
                rvd = rx_data;
            end
            if (!busy && bz < 0) bz = c;
            step();
        end
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_state", {16'h0, busy, rx_valid, spi_sck, spi_mosi, ss_v, rx_data},
            {16'h0, 4'b0000, 4'hF, 8'h00});

        // Fresh select, keep=0, full lead/trail/guard timing.
        kick(2'd3, 1'b0, 8'hA5, 8'h3C);
        watch(1, 90, 3);
        chk("t1_mosi", mosi_cap, 8'hA5);
        chk("t1_nbits", mosi_n, 8);
        chk("t1_ss_first", first, 1);
        chk("t1_ss_last", last, 72);
        chk("t1_rv_cyc", rvc, 69);
        chk("t1_rv_data", rvd, 8'h3C);
        chk("t1_rv_cnt", nrv, 1);
        chk("t1_busy0", bz, 77);
        chk("t1_sck_rise", first_sck, 9);

        // Held select across two bytes on SS2.
        kick(2'd0, 1'b1, 8'h01, 8'h81);
        watch(1, 70, 0);
        chk("t2a_rv_cyc", rvc, 69);
        chk("t2a_busy0", bz, 69);
        chk("t2a_ss_hi", hi_cnt, 0);
        chk("t2a_rx", rvd, 8'h81);
        chk("t2a_mosi", mosi_cap, 8'h01);
        kick(2'd0, 1'b1, 8'hFF, 8'h5A);
        watch(1, 70, 0);
        chk("t2b_rv_cyc", rvc, 65);
        chk("t2b_busy0", bz, 65);
        chk("t2b_ss_hi", hi_cnt, 0);
        chk("t2b_rx", rx_data, 8'h5A);
        chk("t2b_mosi", mosi_cap, 8'hFF);
        chk("t2_ss2_before_rel", spi_ss2_n, 1'b0);
        release_ss = 1'b1;
        step();
        release_ss = 1'b0;
        chk("t2_ss2_after_rel", spi_ss2_n, 1'b1);
        chk("t2_busy_rel", busy, 1'b0);

        // Switch from held SS2 to SS4: gap, lead, then bits.
        kick(2'd0, 1'b1, 8'h00, 8'h00);
        watch(1, 70, 0);
        chk("t3_hold_ss2", spi_ss2_n, 1'b0);
        kick(2'd2, 1'b0, 8'h81, 8'hE7);
        watch(1, 100, 2);
        chk("t3_allhi", allhi, 4);
        chk("t3_ss4_first", first, 5);
        chk("t3_sck_rise", first_sck, 13);
        chk("t3_rv_cyc", rvc, 73);
        chk("t3_rx", rvd, 8'hE7);
        chk("t3_mosi", mosi_cap, 8'h81);
        chk("t3_busy0", bz, 81);

        // Start while busy must be ignored.
        kick(2'd1, 1'b0, 8'hC3, 8'h96);
        repeat (19) step();
        tx_data = 8'h55;
        start = 1'b1;
        step();
        start = 1'b0;
        watch(21, 80, 1);
        chk("t4_rv_cnt", nrv, 1);
        chk("t4_rv_cyc", rvc, 69);
        chk("t4_mosi", mosi_cap, 8'hC3);
        chk("t4_nbits", mosi_n, 8);
        chk("t4_rx", rx_data, 8'h96);
        chk("t4_busy_end", busy, 1'b0);

        // Reset in the middle of a byte.
        kick(2'd3, 1'b0, 8'hA5, 8'h3C);
        repeat (29) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_reset_mid", {16'h0, busy, rx_valid, spi_sck, spi_mosi, ss_v, rx_data},
            {16'h0, 4'b0000, 4'hF, 8'h00});
        watch(32, 80, 3);
        chk("t5_no_rv", nrv, 0);
        chk("t5_ss_stays_hi", first, -1);

        // release together with start on the already-held select.
        kick(2'd1, 1'b1, 8'h11, 8'h22);
        watch(1, 70, 1);
        chk("t6a_rx", rvd, 8'h22);
        release_ss = 1'b1;
        kick(2'd1, 1'b1, 8'h44, 8'h99);
        release_ss = 1'b0;
        watch(1, 70, 1);
        chk("t6_ss3_hi", hi_cnt, 0);
        chk("t6_rv_cyc", rvc, 65);
        chk("t6_rx", rvd, 8'h99);
        chk("t6_mosi", mosi_cap, 8'h44);
        release_ss = 1'b1;
        step();
        release_ss = 1'b0;
        chk("t6_ss3_rel", spi_ss3_n, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
